// File: rtl/slave_bus_arbiter.sv
// Purpose: round-robin master for one slave card shared by two requesters;
//          runs the select/acknowledge handshake, captures read data and
//          aborts hung transactions after TIMEOUT_CYC cycles.
// Latency: grant -> CARD_SEL in SETUP_CYC cycles; SACK_N low -> DONE in 3 cycles.
// Backpressure: requesters hold REQx until DONEx/ERRx; IDLE grants only
//               while the synchronized acknowledge is released.
// Ports:
//   CLK, RESET_N             clock, async active-low reset
//   REQx/WRx_N/ADDRx         requester x command (sampled at grant)
//   GNTx/DONEx/ERRx          requester x ownership and completion pulses
//   RDATA                    read data captured at acknowledge
//   CARD_SEL/AI/WR_IN_N      slave-facing select, address, direction
//   SACK_N/SDO               slave acknowledge (async) and read data
//   BUSY                     arbiter not idle
module slave_bus_arbiter #(
  parameter int TIMEOUT_CYC = 64,
  parameter int SETUP_CYC   = 1
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        REQ0,
  input  logic        WR0_N,
  input  logic [9:0]  ADDR0,
  input  logic        REQ1,
  input  logic        WR1_N,
  input  logic [9:0]  ADDR1,
  output logic        GNT0,
  output logic        GNT1,
  output logic        DONE0,
  output logic        DONE1,
  output logic        ERR0,
  output logic        ERR1,
  output logic [31:0] RDATA,
  output logic        CARD_SEL,
  output logic [9:0]  AI,
  output logic        WR_IN_N,
  input  logic        SACK_N,
  input  logic [31:0] SDO,
  output logic        BUSY
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETUP   = 2'd1;
  localparam logic [1:0] SELECT  = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  // One shared counter serves both the setup hold and the timeout watch.
  localparam logic [7:0] SETUP_LAST   = 8'(SETUP_CYC - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

  logic [1:0] state;
  logic [7:0] cnt;
  logic       owner;    // port holding the bus: 0 or 1
  logic       rr_ptr;   // port that wins the next tie
  logic       sack_meta;
  logic       sack_sync;
  logic       ack;
  logic       win1;

  // SACK_N comes from the card's clock domain; reset to the released level.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sack_meta <= 1'b1;
      sack_sync <= 1'b1;
    end else begin
      sack_meta <= SACK_N;
      sack_sync <= sack_meta;
    end
  end

  assign ack  = ~sack_sync;
  assign win1 = REQ1 & (~REQ0 | rr_ptr);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      owner    <= 1'b0;
      rr_ptr   <= 1'b0;
      GNT0     <= 1'b0;
      GNT1     <= 1'b0;
      DONE0    <= 1'b0;
      DONE1    <= 1'b0;
      ERR0     <= 1'b0;
      ERR1     <= 1'b0;
      RDATA    <= 32'd0;
      CARD_SEL <= 1'b0;
      AI       <= 10'd0;
      WR_IN_N  <= 1'b1;
      BUSY     <= 1'b0;
    end else begin
      DONE0 <= 1'b0;
      DONE1 <= 1'b0;
      ERR0  <= 1'b0;
      ERR1  <= 1'b0;
      case (state)
        IDLE: begin
          // Holding off while ack is still asserted keeps CARD_SEL from
          // rising into a slave that has not released the previous cycle.
          if ((REQ0 | REQ1) && !ack) begin
            owner   <= win1;
            rr_ptr  <= ~win1;
            GNT0    <= ~win1;
            GNT1    <= win1;
            AI      <= win1 ? ADDR1 : ADDR0;
            WR_IN_N <= win1 ? WR1_N : WR0_N;
            cnt     <= 8'd0;
            BUSY    <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            CARD_SEL <= 1'b1;
            cnt      <= 8'd0;
            state    <= SELECT;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        SELECT: begin
          if (ack) begin
            RDATA    <= SDO;
            CARD_SEL <= 1'b0;
            DONE0    <= ~owner;
            DONE1    <= owner;
            cnt      <= 8'd0;
            state    <= RELEASE;
          end else if (cnt == TIMEOUT_LAST) begin
            CARD_SEL <= 1'b0;
            ERR0     <= ~owner;
            ERR1     <= owner;
            cnt      <= 8'd0;
            state    <= RELEASE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RELEASE: begin
          // A slave stuck in acknowledge is abandoned and reported, even if
          // the same transaction already signalled DONE.
          if (!ack || cnt == TIMEOUT_LAST) begin
            ERR0    <= ack & ~owner;
            ERR1    <= ack & owner;
            GNT0    <= 1'b0;
            GNT1    <= 1'b0;
            AI      <= 10'd0;
            WR_IN_N <= 1'b1;
            BUSY    <= 1'b0;
            cnt     <= 8'd0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slave_bus_arbiter.sv
module tb_slave_bus_arbiter;

  logic        CLK = 1'b0;
  logic        RESET_N, REQ0, WR0_N, REQ1, WR1_N, SACK_N;
  logic [9:0]  ADDR0, ADDR1;
  logic [31:0] SDO;

  logic        GNT0, GNT1, DONE0, DONE1, ERR0, ERR1, CARD_SEL, WR_IN_N, BUSY;
  logic [9:0]  AI;
  logic [31:0] RDATA;

  logic        b_gnt0, b_gnt1, b_done0, b_done1, b_err0, b_err1, b_card_sel, b_wr_in_n, b_busy;
  logic [9:0]  b_ai;
  logic [31:0] b_rdata;

  int          checks = 0;
  int          errors = 0;
  logic        last_port;     // model: port served most recently
  logic [31:0] model_rdata;   // model: last captured read data

  always #5 CLK = ~CLK;

  slave_bus_arbiter #(.TIMEOUT_CYC(64), .SETUP_CYC(1)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .REQ0(REQ0), .WR0_N(WR0_N), .ADDR0(ADDR0),
    .REQ1(REQ1), .WR1_N(WR1_N), .ADDR1(ADDR1),
    .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
    .ERR0(ERR0), .ERR1(ERR1), .RDATA(RDATA),
    .CARD_SEL(CARD_SEL), .AI(AI), .WR_IN_N(WR_IN_N),
    .SACK_N(SACK_N), .SDO(SDO), .BUSY(BUSY)
  );

  slave_bus_arbiter #(.TIMEOUT_CYC(64), .SETUP_CYC(3)) dut_setup3 (
    .CLK(CLK), .RESET_N(RESET_N),
    .REQ0(REQ0), .WR0_N(WR0_N), .ADDR0(ADDR0),
    .REQ1(REQ1), .WR1_N(WR1_N), .ADDR1(ADDR1),
    .GNT0(b_gnt0), .GNT1(b_gnt1), .DONE0(b_done0), .DONE1(b_done1),
    .ERR0(b_err0), .ERR1(b_err1), .RDATA(b_rdata),
    .CARD_SEL(b_card_sel), .AI(b_ai), .WR_IN_N(b_wr_in_n),
    .SACK_N(SACK_N), .SDO(SDO), .BUSY(b_busy)
  );

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET_N = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0; WR0_N = 1'b1; WR1_N = 1'b1;
    ADDR0 = 10'h0; ADDR1 = 10'h0; SACK_N = 1'b1; SDO = 32'h0;
    tick(); tick();
    RESET_N = 1'b1;
    tick();
    last_port = 1'b1;
    model_rdata = 32'h0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0; WR0_N = 1'b1; WR1_N = 1'b1;
    ADDR0 = 10'h0; ADDR1 = 10'h0; SACK_N = 1'b1; SDO = 32'h0;
    tick(); tick();
    checks++;
    if ({GNT0, GNT1, DONE0, DONE1, ERR0, ERR1, CARD_SEL, BUSY} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 00000000", {GNT0, GNT1, DONE0, DONE1, ERR0, ERR1, CARD_SEL, BUSY});
    end
    checks++;
    if (AI !== 10'h0 || WR_IN_N !== 1'b1) begin
      errors++;
      $display("FAIL reset_bus: got AI=%h WR_IN_N=%b want AI=000 WR_IN_N=1", AI, WR_IN_N);
    end
    checks++;
    if (RDATA !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h want 00000000", RDATA);
    end
    checks++;
    if ({b_card_sel, b_busy, b_gnt0, b_gnt1} !== 4'h0 || b_wr_in_n !== 1'b1) begin
      errors++;
      $display("FAIL reset_setup3: got %b%b want 00001", {b_card_sel, b_busy, b_gnt0, b_gnt1}, b_wr_in_n);
    end
    RESET_N = 1'b1;
    tick(); tick();
    checks++;
    if (BUSY !== 1'b0 || CARD_SEL !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got BUSY=%b CARD_SEL=%b want 0 0", BUSY, CARD_SEL);
    end
    last_port = 1'b1;
    model_rdata = 32'h0;
  endtask

  task automatic test_single_read();
    REQ0 = 1'b1; ADDR0 = 10'h123; WR0_N = 1'b1; SDO = 32'hDEADBEEF;
    tick();
    checks++;
    if ({GNT0, GNT1, BUSY, CARD_SEL} !== 4'b1010 || AI !== 10'h123 || WR_IN_N !== 1'b1) begin
      errors++;
      $display("FAIL read_grant: got gnt0/gnt1/busy/sel=%b AI=%h WR_IN_N=%b want 1010 123 1",
               {GNT0, GNT1, BUSY, CARD_SEL}, AI, WR_IN_N);
    end
    tick();
    checks++;
    if (CARD_SEL !== 1'b1) begin
      errors++;
      $display("FAIL read_setup: got CARD_SEL=%b want 1", CARD_SEL);
    end
    tick(); tick();
    SACK_N = 1'b0;
    tick(); tick();
    checks++;
    if (DONE0 !== 1'b0) begin
      errors++;
      $display("FAIL read_early_done: got DONE0=%b want 0", DONE0);
    end
    tick();
    checks++;
    if (DONE0 !== 1'b1 || RDATA !== 32'hDEADBEEF || CARD_SEL !== 1'b0) begin
      errors++;
      $display("FAIL read_done: got DONE0=%b RDATA=%h CARD_SEL=%b want 1 deadbeef 0", DONE0, RDATA, CARD_SEL);
    end
    REQ0 = 1'b0;
    tick();
    checks++;
    if (DONE0 !== 1'b0 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL read_pulse: got DONE0=%b BUSY=%b want 0 1", DONE0, BUSY);
    end
    SACK_N = 1'b1;
    tick(); tick();
    checks++;
    if (BUSY !== 1'b1 || GNT0 !== 1'b1) begin
      errors++;
      $display("FAIL read_release_hold: got BUSY=%b GNT0=%b want 1 1", BUSY, GNT0);
    end
    tick();
    checks++;
    if (BUSY !== 1'b0 || GNT0 !== 1'b0 || AI !== 10'h0 || WR_IN_N !== 1'b1) begin
      errors++;
      $display("FAIL read_idle: got BUSY=%b GNT0=%b AI=%h WR_IN_N=%b want 0 0 000 1", BUSY, GNT0, AI, WR_IN_N);
    end
    last_port = 1'b0;
    model_rdata = 32'hDEADBEEF;
  endtask

  task automatic test_round_robin();
    int          grants = 0;
    int          overlap = 0;
    int          n = 0;
    logic        prev_g0 = 1'b0;
    logic        prev_g1 = 1'b0;
    logic        exp_port;
    logic [31:0] sent = 32'h0;
    do_reset();
    exp_port = ~last_port;
    REQ0 = 1'b1; REQ1 = 1'b1; ADDR0 = 10'h011; ADDR1 = 10'h322;
    while ((grants < 6 || BUSY || !SACK_N) && n < 400) begin
      tick();
      n++;
      if (GNT0 && GNT1) overlap++;
      if ((GNT0 && !prev_g0) || (GNT1 && !prev_g1)) begin
        grants++;
        checks++;
        if (GNT1 !== exp_port || GNT0 !== ~exp_port || prev_g0 || prev_g1) begin
          errors++;
          $display("FAIL rr_grant #%0d: got gnt1/gnt0=%b%b (prev %b%b) want port %0d after idle gap",
                   grants, GNT1, GNT0, prev_g1, prev_g0, exp_port);
        end
        last_port = exp_port;
        exp_port = ~exp_port;
        if (grants == 6) begin
          REQ0 = 1'b0;
          REQ1 = 1'b0;
        end
      end
      if (DONE0 || DONE1) begin
        checks++;
        if (RDATA !== sent) begin
          errors++;
          $display("FAIL rr_rdata: got %h want %h", RDATA, sent);
        end
        model_rdata = sent;
      end
      prev_g0 = GNT0;
      prev_g1 = GNT1;
      if (CARD_SEL && SACK_N) begin
        sent = $urandom;
        SDO = sent;
        SACK_N = 1'b0;
      end else if (!CARD_SEL && !SACK_N) begin
        SACK_N = 1'b1;
      end
    end
    checks++;
    if (grants != 6 || overlap != 0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL rr_summary: got grants=%0d overlap=%0d BUSY=%b want 6 0 0", grants, overlap, BUSY);
    end
  endtask

  task automatic test_timeout();
    int hi = 0;
    int err_at = 0;
    int errs = 0;
    int dones = 0;
    REQ1 = 1'b1; ADDR1 = 10'h2A5; WR1_N = 1'b0;
    tick();
    checks++;
    if ({GNT1, GNT0, AI, WR_IN_N} !== {1'b1, 1'b0, 10'h2A5, 1'b0}) begin
      errors++;
      $display("FAIL to_grant: got gnt1=%b gnt0=%b AI=%h WR_IN_N=%b want 1 0 2a5 0", GNT1, GNT0, AI, WR_IN_N);
    end
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (CARD_SEL) hi++;
      if (DONE0 || DONE1) dones++;
      if (ERR0 || ERR1) errs++;
      if (ERR1) begin
        err_at = i;
        REQ1 = 1'b0;
      end
      if (!BUSY) break;
    end
    checks++;
    if (hi != 64) begin
      errors++;
      $display("FAIL to_sel_width: got %0d cycles want 64", hi);
    end
    checks++;
    if (errs != 1 || err_at != 65) begin
      errors++;
      $display("FAIL to_err: got %0d pulses at cycle %0d want 1 at 65", errs, err_at);
    end
    checks++;
    if (dones != 0 || RDATA !== model_rdata || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL to_after: got dones=%0d RDATA=%h BUSY=%b want 0 %h 0", dones, RDATA, BUSY, model_rdata);
    end
    last_port = 1'b1;
  endtask

  task automatic test_stuck_ack();
    int          done_at = 0;
    int          err_at = 0;
    int          g1_at = 0;
    logic        busy_mid = 1'b1;
    logic        done1 = 1'b0;
    logic [31:0] sdo1;
    logic [31:0] sdo2;
    sdo1 = $urandom;
    sdo2 = $urandom;
    REQ0 = 1'b1; ADDR0 = 10'($urandom); WR0_N = 1'b0;
    tick(); tick();
    SDO = sdo1; SACK_N = 1'b0; REQ1 = 1'b1;
    for (int i = 1; i <= 330; i++) begin
      tick();
      if (DONE0) begin
        done_at = i;
        REQ0 = 1'b0;
      end
      if (ERR0) err_at = i;
      if (i == 100) busy_mid = BUSY;
      if (GNT1 && g1_at == 0) g1_at = i;
      if (i == 300) SACK_N = 1'b1;
      if (g1_at != 0) break;
    end
    checks++;
    if (done_at != 3 || err_at != 67) begin
      errors++;
      $display("FAIL stuck_done_err: got done@%0d err@%0d want done@3 err@67", done_at, err_at);
    end
    checks++;
    if (busy_mid !== 1'b0) begin
      errors++;
      $display("FAIL stuck_idle: got BUSY=%b want 0 after forced abort", busy_mid);
    end
    checks++;
    if (g1_at != 303) begin
      errors++;
      $display("FAIL stuck_hold_grant: got GNT1 at %0d want 303", g1_at);
    end
    for (int i = 0; i < 30 && !(done1 && !BUSY); i++) begin
      if (CARD_SEL && SACK_N && !done1) begin
        SDO = sdo2;
        SACK_N = 1'b0;
      end
      tick();
      if (DONE1) begin
        done1 = 1'b1;
        REQ1 = 1'b0;
        SACK_N = 1'b1;
        checks++;
        if (RDATA !== sdo2) begin
          errors++;
          $display("FAIL stuck_next_rdata: got %h want %h", RDATA, sdo2);
        end
      end
    end
    checks++;
    if (done1 !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL stuck_next_done: got done=%b BUSY=%b want 1 0", done1, BUSY);
    end
    model_rdata = sdo2;
    last_port = 1'b1;
  endtask

  task automatic test_reset_mid();
    int          pulses = 0;
    logic [31:0] sdo;
    sdo = $urandom;
    REQ0 = 1'b1; ADDR0 = 10'h0F0; WR0_N = 1'b1;
    tick(); tick(); tick();
    #2 RESET_N = 1'b0;
    #1;
    checks++;
    if ({CARD_SEL, GNT0, GNT1, BUSY} !== 4'h0) begin
      errors++;
      $display("FAIL rst_mid_async: got sel/g0/g1/busy=%b want 0000", {CARD_SEL, GNT0, GNT1, BUSY});
    end
    REQ0 = 1'b0;
    tick();
    RESET_N = 1'b1;
    last_port = 1'b1;
    model_rdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (DONE0 || DONE1 || ERR0 || ERR1) pulses++;
    end
    checks++;
    if (pulses != 0 || RDATA !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_quiet: got pulses=%0d RDATA=%h want 0 00000000", pulses, RDATA);
    end
    REQ0 = 1'b1; ADDR0 = 10'h0AB; WR0_N = 1'b0;
    tick();
    checks++;
    if (GNT0 !== 1'b1 || AI !== 10'h0AB || WR_IN_N !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_regrant: got GNT0=%b AI=%h WR_IN_N=%b want 1 0ab 0", GNT0, AI, WR_IN_N);
    end
    tick();
    SDO = sdo; SACK_N = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (DONE0 !== 1'b1 || RDATA !== sdo) begin
      errors++;
      $display("FAIL rst_mid_done: got DONE0=%b RDATA=%h want 1 %h", DONE0, RDATA, sdo);
    end
    REQ0 = 1'b0; SACK_N = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_idle: got BUSY=%b want 0", BUSY);
    end
    last_port = 1'b0;
    model_rdata = sdo;
  endtask

  task automatic test_setup3();
    logic [31:0] sdo;
    sdo = $urandom;
    do_reset();
    REQ0 = 1'b1; ADDR0 = 10'h155; WR0_N = 1'b1;
    tick();
    checks++;
    if (b_gnt0 !== 1'b1 || b_ai !== 10'h155 || b_card_sel !== 1'b0) begin
      errors++;
      $display("FAIL s3_grant: got gnt0=%b AI=%h sel=%b want 1 155 0", b_gnt0, b_ai, b_card_sel);
    end
    tick();
    ADDR0 = 10'h3FF;
    checks++;
    if (b_card_sel !== 1'b0) begin
      errors++;
      $display("FAIL s3_hold1: got CARD_SEL=%b want 0", b_card_sel);
    end
    tick();
    checks++;
    if (b_card_sel !== 1'b0 || b_ai !== 10'h155) begin
      errors++;
      $display("FAIL s3_hold2: got CARD_SEL=%b AI=%h want 0 155", b_card_sel, b_ai);
    end
    tick();
    checks++;
    if (b_card_sel !== 1'b1 || b_ai !== 10'h155) begin
      errors++;
      $display("FAIL s3_select: got CARD_SEL=%b AI=%h want 1 155", b_card_sel, b_ai);
    end
    SDO = sdo; SACK_N = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (b_done0 !== 1'b1 || b_rdata !== sdo) begin
      errors++;
      $display("FAIL s3_done: got DONE0=%b RDATA=%h want 1 %h", b_done0, b_rdata, sdo);
    end
    REQ0 = 1'b0; SACK_N = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (b_busy !== 1'b0) begin
      errors++;
      $display("FAIL s3_idle: got BUSY=%b want 0", b_busy);
    end
  endtask

  task automatic test_random();
    logic [9:0]  addr [2];
    logic        wr [2];
    logic [1:0]  pending;
    logic        exp_p;
    logic [31:0] sdo;
    int          w;
    do_reset();
    for (int it = 0; it < 25; it++) begin
      pending = 2'($urandom_range(1, 3));
      addr[0] = 10'($urandom); addr[1] = 10'($urandom);
      wr[0] = 1'($urandom); wr[1] = 1'($urandom);
      ADDR0 = addr[0]; WR0_N = wr[0]; ADDR1 = addr[1]; WR1_N = wr[1];
      REQ0 = pending[0]; REQ1 = pending[1];
      while (pending != 2'b00) begin
        exp_p = (pending == 2'b11) ? ~last_port : pending[1];
        w = 0;
        do begin
          tick();
          w++;
        end while (!(GNT0 || GNT1) && w < 10);
        checks++;
        if (w != 1 || GNT1 !== exp_p || GNT0 !== ~exp_p) begin
          errors++;
          $display("FAIL rand_grant it%0d: got gnt1/gnt0=%b%b after %0d cycles want port %0d after 1",
                   it, GNT1, GNT0, w, exp_p);
        end
        checks++;
        if (AI !== addr[exp_p] || WR_IN_N !== wr[exp_p]) begin
          errors++;
          $display("FAIL rand_cmd it%0d: got AI=%h WR_IN_N=%b want %h %b", it, AI, WR_IN_N, addr[exp_p], wr[exp_p]);
        end
        // Owner's command lines and request wiggle after grant; must not matter.
        if ($urandom_range(0, 1) == 1) begin
          if (exp_p) begin ADDR1 = ~ADDR1; WR1_N = ~WR1_N; end
          else begin ADDR0 = ~ADDR0; WR0_N = ~WR0_N; end
        end
        if ($urandom_range(0, 3) == 0) begin
          if (exp_p) REQ1 = 1'b0; else REQ0 = 1'b0;
        end
        tick();
        checks++;
        if (CARD_SEL !== 1'b1 || AI !== addr[exp_p]) begin
          errors++;
          $display("FAIL rand_setup it%0d: got CARD_SEL=%b AI=%h want 1 %h", it, CARD_SEL, AI, addr[exp_p]);
        end
        if ($urandom_range(0, 5) == 0) begin
          repeat (64) tick();
          checks++;
          if ((exp_p ? ERR1 : ERR0) !== 1'b1 || (DONE0 | DONE1) !== 1'b0 || CARD_SEL !== 1'b0 ||
              RDATA !== model_rdata) begin
            errors++;
            $display("FAIL rand_timeout it%0d: got err1/err0=%b%b done=%b sel=%b RDATA=%h want port %0d err, %h",
                     it, ERR1, ERR0, DONE0 | DONE1, CARD_SEL, RDATA, exp_p, model_rdata);
          end
          if (exp_p) REQ1 = 1'b0; else REQ0 = 1'b0;
          tick();
        end else begin
          repeat ($urandom_range(0, 3)) tick();
          sdo = $urandom;
          SDO = sdo;
          SACK_N = 1'b0;
          tick(); tick(); tick();
          checks++;
          if ((exp_p ? DONE1 : DONE0) !== 1'b1 || RDATA !== sdo || CARD_SEL !== 1'b0) begin
            errors++;
            $display("FAIL rand_done it%0d: got done1/done0=%b%b RDATA=%h sel=%b want port %0d, %h, 0",
                     it, DONE1, DONE0, RDATA, CARD_SEL, exp_p, sdo);
          end
          model_rdata = sdo;
          if (exp_p) REQ1 = 1'b0; else REQ0 = 1'b0;
          repeat ($urandom_range(0, 3)) tick();
          SACK_N = 1'b1;
          tick(); tick(); tick();
        end
        checks++;
        if ({GNT0, GNT1, BUSY} !== 3'b000) begin
          errors++;
          $display("FAIL rand_idle it%0d: got gnt0/gnt1/busy=%b want 000", it, {GNT0, GNT1, BUSY});
        end
        last_port = exp_p;
        pending[exp_p] = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_timeout();
    test_stuck_ack();
    test_reset_mid();
    test_setup3();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/slave_bus_arbiter.md
Name: slave_bus_arbiter

Overview:
Card-bus master that shares one slave card's bus (CARD_SEL/AI/WR_IN_N/SACK_N/SDO) between two requesters, port 0 and port 1.
- Arbitrates between them round-robin.
- Runs a 4-phase select/acknowledge handshake with the slave and returns read data.
- Aborts hung transactions with a timeout.
Sits between the host-side interface logic and the slave card.

Parameters:
TIMEOUT_CYC, 64, max cycles to wait for SACK_N low (assert) or SACK_N high (release) before abort; legal range 2..255
SETUP_CYC, 1, cycles AI/WR_IN_N are held stable before CARD_SEL asserts; legal range 1..7

Ports:
CLK  in  1  system clock, rising edge
RESET_N  in  1  asynchronous, active-low reset
REQ0  in  1  port 0 request, level; held until DONE0 or ERR0
WR0_N  in  1  port 0 direction, 0=write 1=read; sampled at grant
ADDR0  in  10  port 0 card address, sampled at grant
REQ1  in  1  port 1 request
WR1_N  in  1  port 1 direction
ADDR1  in  10  port 1 address
GNT0  out  1  port 0 owns bus; high from grant to completion
GNT1  out  1  port 1 owns bus
DONE0  out  1  one-cycle pulse: port 0 transaction acknowledged
DONE1  out  1  one-cycle pulse: port 1 transaction acknowledged
ERR0  out  1  one-cycle pulse: port 0 transaction timed out
ERR1  out  1  one-cycle pulse: port 1 transaction timed out
RDATA  out  32  SDO captured at acknowledge; held until next capture
CARD_SEL  out  1  card select to slave, active-high
AI  out  10  address to slave
WR_IN_N  out  1  write strobe direction to slave
SACK_N  in  1  slave acknowledge, active-low; asynchronous to CLK
SDO  in  32  slave read data, valid while SACK_N low
BUSY  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, RESET_N=0) sets these outputs:
  - State=IDLE.
  - CARD_SEL=0, AI=0, WR_IN_N=1.
  - GNT*=0, DONE*=0, ERR*=0, BUSY=0, RDATA=0.
  - Round-robin pointer=port 0 priority.
- Reset mid-transaction drops CARD_SEL at once. No DONE or ERR is issued.
- SACK_N passes through a 2-flop synchronizer before use. Rule-facing value is ack = ~SACK_N_sync.
- All outputs are registered.

State machine (IDLE, SETUP, SELECT, RELEASE):
- IDLE:
  - Requests are evaluated each cycle.
  - Only one requester: it wins.
  - Both requesting: the port not served last wins (pointer toggles after each grant). After reset, port 0 wins the first tie.
  - On grant, in the next cycle:
    - GNTx=1.
    - AI=ADDRx and WR_IN_N=WRx_N are latched.
    - Go to SETUP.
- SETUP:
  - Hold AI/WR_IN_N for SETUP_CYC cycles, then CARD_SEL=1 and go to SELECT.
  - Timeout counter clears.
- SELECT:
  - Counter increments each cycle.
  - If ack=1:
    - RDATA<=SDO (captured on reads and on writes).
    - CARD_SEL<=0.
    - DONEx pulses in the same cycle as the capture edge.
    - Go to RELEASE, counter cleared.
  - If counter reaches TIMEOUT_CYC with ack=0:
    - CARD_SEL<=0.
    - ERRx pulses.
    - RDATA unchanged.
    - Go to RELEASE.
- RELEASE:
  - Wait for ack=0 (SACK_N sync high), then go to IDLE.
  - On that transition: GNTx<=0, AI<=0, WR_IN_N<=1.
  - If ack is still 1 after TIMEOUT_CYC cycles, force IDLE anyway and pulse ERRx. A port can therefore see DONE then ERR for the same transaction.

Timing and requester rules:
- Minimum transaction, SETUP_CYC=1, slave acks immediately:
  - Grant → CARD_SEL high = 1 cycle.
  - SACK_N low → DONE = 3 cycles (2 sync + capture).
  - Back-to-back grants have ≥1 IDLE cycle between them.
- REQx dropped while GNTx=1 is ignored; the transaction completes.
- REQx still high in the cycle after DONE/ERR is treated as a new request.
- WRx_N/ADDRx changes after grant have no effect.
- CARD_SEL never asserts while SACK_N_sync is low: IDLE only grants when ack=0.

Test Plan:
- Reset, REQ0=1, ADDR0=0x123, WR0_N=1; slave drives SDO=0xDEADBEEF and pulls SACK_N low 2 cycles after CARD_SEL → GNT0, AI=0x123, WR_IN_N=1, CARD_SEL after 1 setup cycle, DONE0 single pulse, RDATA=0xDEADBEEF, CARD_SEL low, IDLE after SACK_N high.
- REQ0 and REQ1 held high continuously, slave always acks → grants alternate 0,1,0,1; first grant port 0; never GNT0&GNT1 together.
- REQ1=1 ADDR1=0x2A5 WR1_N=0, slave never acks, TIMEOUT_CYC=64 → CARD_SEL high exactly 64 cycles, ERR1 pulse, no DONE1, RDATA unchanged, BUSY falls.
- Slave acks, then holds SACK_N low 300 cycles → DONE0 then, after 64 RELEASE cycles, ERR0 pulse and return to IDLE; next REQ1 not granted until SACK_N high.
- RESET_N pulled low while in SELECT → CARD_SEL, GNT*, BUSY go 0 asynchronously; no DONE/ERR; new request after reset is served normally.
- SETUP_CYC=3; change ADDR0 to 0x3FF one cycle after grant → AI holds original value; CARD_SEL rises 3 cycles after AI valid.
